// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX stage: ALU codes, operand selects,
// forwarding source codes and the stage-register layout.
package id_ex_stage_pkg;

  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_XOR = 4'd4;
  localparam logic [3:0] EXE_ALU_SLT = 4'd5;
  localparam logic [3:0] EXE_ALU_SLL = 4'd6;
  localparam logic [3:0] EXE_ALU_SRL = 4'd7;
  localparam logic [3:0] EXE_ALU_SRA = 4'd8;
  localparam logic [3:0] EXE_ALU_LUI = 4'd9;

  localparam logic EXE_A_RS  = 1'b0;
  localparam logic EXE_A_SA  = 1'b1;
  localparam logic EXE_B_RT  = 1'b0;
  localparam logic EXE_B_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] imm;
    logic [4:0]  sa;
    logic [3:0]  oper;
    logic        a_sel;
    logic        b_sel;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        mem_ren;
    logic        mem_wen;
  } stage_t;

  function automatic stage_t bubble();
    stage_t s;
    s      = '0;
    s.oper = EXE_ALU_ADD;
    return s;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Combinational operand source selector: MEM result, WB data, or latched
// register-file data. Register 0 is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  input  logic        mem_wb_en,
  input  logic [4:0]  mem_wb_addr,
  input  logic [31:0] mem_alu_result,
  input  logic        wb_wb_en,
  input  logic [4:0]  wb_wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);

  fwd_sel_e sel;

  // MEM is the younger producer, so it is checked before WB.
  always_comb begin
    sel = FWD_NONE;
    if (reg_addr != '0) begin
      if (mem_wb_en && (mem_wb_addr == reg_addr))
        sel = FWD_MEM;
      else if (wb_wb_en && (wb_wb_addr == reg_addr))
        sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_MEM: data = mem_alu_result;
      FWD_WB:  data = wb_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// bubble insertion, feeding the EX-stage ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_sa,
  input  logic [3:0]  id_alu_oper,
  input  logic        id_a_sel,
  input  logic        id_b_sel,
  input  logic        id_wb_en,
  input  logic [4:0]  id_wb_addr,
  input  logic        id_mem_ren,
  input  logic        id_mem_wen,
  input  logic        mem_wb_en,
  input  logic [4:0]  mem_wb_addr,
  input  logic [31:0] mem_alu_result,
  input  logic        wb_wb_en,
  input  logic [4:0]  wb_wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_oper,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_store_data,
  output logic        ex_wb_en,
  output logic [4:0]  ex_wb_addr,
  output logic        ex_mem_ren,
  output logic        ex_mem_wen,
  output logic        load_use
);

  stage_t      q, d;
  logic [31:0] fwd_rs, fwd_rt;

  // Conservative: a match on rt stalls even if ID does not read rt.
  always_comb begin
    load_use = q.valid && q.mem_ren && q.wb_en && (q.wb_addr != '0) && id_valid &&
               ((q.wb_addr == id_rs_addr) || (q.wb_addr == id_rt_addr));
  end

  always_comb begin
    d = q;
    if (!stall) begin
      if (flush || load_use || !id_valid) begin
        d = bubble();
      end else begin
        d.valid   = 1'b1;
        d.pc      = id_pc;
        d.rs_data = id_rs_data;
        d.rt_data = id_rt_data;
        d.rs_addr = id_rs_addr;
        d.rt_addr = id_rt_addr;
        d.imm     = id_imm;
        d.sa      = id_sa;
        d.oper    = id_alu_oper;
        d.a_sel   = id_a_sel;
        d.b_sel   = id_b_sel;
        d.wb_en   = id_wb_en;
        d.wb_addr = id_wb_addr;
        d.mem_ren = id_mem_ren;
        d.mem_wen = id_mem_wen;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= bubble();
    else     q <= d;
  end

  fwd_mux u_fwd_rs (
    .reg_addr       (q.rs_addr),
    .reg_data       (q.rs_data),
    .mem_wb_en      (mem_wb_en),
    .mem_wb_addr    (mem_wb_addr),
    .mem_alu_result (mem_alu_result),
    .wb_wb_en       (wb_wb_en),
    .wb_wb_addr     (wb_wb_addr),
    .wb_data        (wb_data),
    .data           (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .reg_addr       (q.rt_addr),
    .reg_data       (q.rt_data),
    .mem_wb_en      (mem_wb_en),
    .mem_wb_addr    (mem_wb_addr),
    .mem_alu_result (mem_alu_result),
    .wb_wb_en       (wb_wb_en),
    .wb_wb_addr     (wb_wb_addr),
    .wb_data        (wb_data),
    .data           (fwd_rt)
  );

  assign alu_a         = (q.a_sel == EXE_A_SA)  ? {27'b0, q.sa} : fwd_rs;
  assign alu_b         = (q.b_sel == EXE_B_IMM) ? q.imm         : fwd_rt;
  assign alu_oper      = q.oper;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = q.valid;
  assign ex_pc         = q.pc;
  assign ex_wb_en      = q.wb_en;
  assign ex_wb_addr    = q.wb_addr;
  assign ex_mem_ren    = q.mem_ren;
  assign ex_mem_wen    = q.mem_wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts every output,
// expectations are queued when stimulus is applied and checked on DUT output.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid, id_a_sel, id_b_sel, id_wb_en, id_mem_ren, id_mem_wen;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_sa, id_wb_addr;
  logic [3:0]  id_alu_oper;
  logic        mem_wb_en, wb_wb_en;
  logic [4:0]  mem_wb_addr, wb_wb_addr;
  logic [31:0] mem_alu_result, wb_data;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]  alu_oper;
  logic        ex_valid, ex_wb_en, ex_mem_ren, ex_mem_wen, load_use;
  logic [4:0]  ex_wb_addr;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_imm(id_imm), .id_sa(id_sa),
    .id_alu_oper(id_alu_oper), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen),
    .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr), .mem_alu_result(mem_alu_result),
    .wb_wb_en(wb_wb_en), .wb_wb_addr(wb_wb_addr), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
    .load_use(load_use)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, sa, wb_addr;
    logic [3:0]  oper;
    logic        a_sel, b_sel, wb_en, mem_ren, mem_wen;
  } mstate_t;

  typedef struct {
    string       tag;
    logic [31:0] alu_a, alu_b, pc, store;
    logic [3:0]  oper;
    logic [4:0]  wb_addr;
    logic        valid, wb_en, mem_ren, mem_wen, load_use;
  } exp_t;

  mstate_t m;
  exp_t    sb[$];
  int      n_vec = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic mstate_t m_bubble();
    mstate_t s;
    s = '{valid: 1'b0, pc: '0, rs_data: '0, rt_data: '0, imm: '0, rs_addr: '0, rt_addr: '0,
          sa: '0, wb_addr: '0, oper: EXE_ALU_ADD, a_sel: 1'b0, b_sel: 1'b0, wb_en: 1'b0,
          mem_ren: 1'b0, mem_wen: 1'b0};
    return s;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] latched);
    if (a == 5'd0) return latched;
    if (mem_wb_en && mem_wb_addr == a) return mem_alu_result;
    if (wb_wb_en && wb_wb_addr == a) return wb_data;
    return latched;
  endfunction

  function automatic logic m_lu(input mstate_t s);
    return s.valid && s.mem_ren && s.wb_en && s.wb_addr != 5'd0 && id_valid &&
           (s.wb_addr == id_rs_addr || s.wb_addr == id_rt_addr);
  endfunction

  function automatic exp_t predict(input mstate_t s, input string tag);
    exp_t e;
    e.tag      = tag;
    e.alu_a    = s.a_sel ? {27'd0, s.sa} : m_fwd(s.rs_addr, s.rs_data);
    e.alu_b    = s.b_sel ? s.imm : m_fwd(s.rt_addr, s.rt_data);
    e.store    = m_fwd(s.rt_addr, s.rt_data);
    e.pc       = s.pc;
    e.oper     = s.oper;
    e.wb_addr  = s.wb_addr;
    e.valid    = s.valid;
    e.wb_en    = s.wb_en;
    e.mem_ren  = s.mem_ren;
    e.mem_wen  = s.mem_wen;
    e.load_use = m_lu(s);
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".alu_a"},    alu_a,                e.alu_a);
    check({e.tag, ".alu_b"},    alu_b,                e.alu_b);
    check({e.tag, ".store"},    ex_store_data,        e.store);
    check({e.tag, ".pc"},       ex_pc,                e.pc);
    check({e.tag, ".oper"},     {28'd0, alu_oper},    {28'd0, e.oper});
    check({e.tag, ".wb_addr"},  {27'd0, ex_wb_addr},  {27'd0, e.wb_addr});
    check({e.tag, ".valid"},    {31'd0, ex_valid},    {31'd0, e.valid});
    check({e.tag, ".wb_en"},    {31'd0, ex_wb_en},    {31'd0, e.wb_en});
    check({e.tag, ".mem_ren"},  {31'd0, ex_mem_ren},  {31'd0, e.mem_ren});
    check({e.tag, ".mem_wen"},  {31'd0, ex_mem_wen},  {31'd0, e.mem_wen});
    check({e.tag, ".load_use"}, {31'd0, load_use},    {31'd0, e.load_use});
  endtask

  // Same-cycle check after changing only combinational inputs.
  task automatic probe(input string tag);
    sb.push_back(predict(m, tag));
    #1;
    pop_check();
  endtask

  // One clock: model next state, queue expectation, advance, compare.
  task automatic step(input string tag);
    mstate_t nxt;
    nxt = m;
    if (rst) nxt = m_bubble();
    else if (!stall) begin
      if (flush || m_lu(m) || !id_valid) nxt = m_bubble();
      else nxt = '{valid: 1'b1, pc: id_pc, rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                   rs_addr: id_rs_addr, rt_addr: id_rt_addr, sa: id_sa, wb_addr: id_wb_addr,
                   oper: id_alu_oper, a_sel: id_a_sel, b_sel: id_b_sel, wb_en: id_wb_en,
                   mem_ren: id_mem_ren, mem_wen: id_mem_wen};
    end
    sb.push_back(predict(nxt, tag));
    @(posedge clk);
    m = nxt;
    #1;
    pop_check();
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [3:0] oper,
                        input logic wben, input logic [4:0] wba, input logic mren);
    id_valid = 1'b1; id_pc = pc; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_alu_oper = oper;
    id_wb_en = wben; id_wb_addr = wba; id_mem_ren = mren; id_mem_wen = 1'b0;
    id_a_sel = EXE_A_RS; id_b_sel = EXE_B_RT; id_imm = 32'h0; id_sa = 5'd0;
  endtask

  task automatic clr_fwd();
    mem_wb_en = 1'b0; mem_wb_addr = '0; mem_alu_result = '0;
    wb_wb_en = 1'b0; wb_wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, EXE_ALU_ADD, 1'b0, 5'd0, 1'b0);
    id_valid = 1'b0;
    clr_fwd();
    m = m_bubble();
    probe("reset");
    step("reset_edge");
    rst = 1'b0;

    // Plain capture, then MEM/WB forwarding priority on rs and rt
    set_id(32'h100, 5'd5, 32'h1, 5'd6, 32'h2, EXE_ALU_ADD, 1'b1, 5'd7, 1'b0);
    step("capture_add");
    mem_wb_en = 1'b1; mem_wb_addr = 5'd5; mem_alu_result = 32'h1234;
    probe("fwd_mem_rs");
    wb_wb_en = 1'b1; wb_wb_addr = 5'd5; wb_data = 32'h9999;
    probe("fwd_mem_beats_wb");
    wb_wb_addr = 5'd6;
    probe("fwd_wb_rt");
    clr_fwd();

    // Register 0 is never forwarded
    set_id(32'h104, 5'd0, 32'h55, 5'd0, 32'h66, EXE_ALU_OR, 1'b1, 5'd3, 1'b0);
    mem_wb_en = 1'b1; mem_wb_addr = 5'd0; mem_alu_result = 32'hDEAD;
    step("r0_no_fwd");
    clr_fwd();

    // Asynchronous reset between edges
    set_id(32'h108, 5'd2, 32'h22, 5'd3, 32'h33, EXE_ALU_ADD, 1'b1, 5'd4, 1'b0);
    step("pre_reset_add");
    #2;
    rst = 1'b1;
    m = m_bubble();
    probe("async_reset");
    step("reset_held_edge");
    rst = 1'b0;

    // Shift amount / immediate operand selects
    set_id(32'h10C, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, EXE_ALU_SLL, 1'b1, 5'd9, 1'b0);
    id_a_sel = EXE_A_SA; id_sa = 5'd4; id_b_sel = EXE_B_IMM; id_imm = 32'hF;
    step("sll_imm");

    // Load-use: bubble, then WB forwarding resolves the dependence
    set_id(32'h110, 5'd0, 32'h0, 5'd0, 32'h0, EXE_ALU_ADD, 1'b1, 5'd8, 1'b1);
    step("lw_r8");
    set_id(32'h114, 5'd8, 32'h0, 5'd1, 32'h7, EXE_ALU_ADD, 1'b1, 5'd9, 1'b0);
    probe("load_use_detect");
    step("load_use_bubble");
    wb_wb_en = 1'b1; wb_wb_addr = 5'd8; wb_data = 32'hCAFE;
    step("load_use_resolved");
    clr_fwd();

    // Stall with pending load-use: hold, load_use persists, then bubble
    set_id(32'h118, 5'd0, 32'h0, 5'd0, 32'h0, EXE_ALU_ADD, 1'b1, 5'd10, 1'b1);
    step("lw_r10");
    set_id(32'h11C, 5'd3, 32'h3, 5'd10, 32'h0, EXE_ALU_SUB, 1'b1, 5'd11, 1'b0);
    stall = 1'b1;
    step("stall_load_use");
    stall = 1'b0;
    step("load_use_after_stall");

    // Stall beats flush; flush alone yields a bubble
    set_id(32'h120, 5'd4, 32'h44, 5'd5, 32'h55, EXE_ALU_XOR, 1'b1, 5'd12, 1'b0);
    step("pre_stall");
    set_id(32'h124, 5'd6, 32'h66, 5'd7, 32'h77, EXE_ALU_AND, 1'b1, 5'd13, 1'b0);
    stall = 1'b1; flush = 1'b1;
    step("stall_flush_1");
    mem_wb_en = 1'b1; mem_wb_addr = 5'd4; mem_alu_result = 32'h4444_0000;
    step("stall_flush_2_fwd");
    stall = 1'b0;
    step("flush_bubble");
    flush = 1'b0;
    clr_fwd();

    // Randomised traffic over a narrow register range to provoke hazards
    for (int i = 0; i < 40; i++) begin
      set_id($urandom, 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
             4'($urandom_range(0, 9)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      id_valid = ($urandom_range(0, 7) != 0);
      id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
      id_sa = 5'($urandom); id_imm = $urandom; id_mem_wen = 1'($urandom);
      mem_wb_en = 1'($urandom); mem_wb_addr = 5'($urandom_range(0, 3)); mem_alu_result = $urandom;
      wb_wb_en = 1'($urandom); wb_wb_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
